// File: rtl/life_sequencer.sv
// Generation register and run controller for the 8x8 Game of Life.
// Holds the grid, captures the datapath result on commit, and sequences seed/run/step/halt.
//
// state | meaning
// IDLE  | paused; step performs one commit, start enters RUN
// RUN   | free-running; commits every period+1 cycles
// HALT  | still-life or extinction reached; frozen until load or reset
module life_sequencer #(
  parameter int GEN_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      seed,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [DIV_W-1:0] period,
  input  logic [63:0]      grid_next,
  output logic [63:0]      grid,
  output logic [GEN_W-1:0] gen_count,
  output logic             gen_tick,
  output logic             running,
  output logic             stable,
  output logic             extinct
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] divider;

  logic             div_due;
  logic             nxt_stable;
  logic             nxt_extinct;
  logic             halt_hit;
  logic             do_commit;
  logic [GEN_W-1:0] gen_count_inc;

  // Commit decision folds in the priority load > stop > start > step > divider.
  always_comb begin
    div_due       = (divider >= period);
    nxt_stable    = (grid_next == grid);
    nxt_extinct   = (grid_next == 64'd0);
    halt_hit      = nxt_stable | nxt_extinct;
    gen_count_inc = (&gen_count) ? gen_count : gen_count + GEN_W'(1);
    do_commit     = 1'b0;
    case (state)
      IDLE:    do_commit = !start && step;
      RUN:     do_commit = !stop && div_due;
      default: do_commit = 1'b0;
    endcase
    if (load) do_commit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      divider   <= '0;
      grid      <= '0;
      gen_count <= '0;
      gen_tick  <= 1'b0;
      running   <= 1'b0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
    end else begin
      gen_tick <= 1'b0;
      if (load) begin
        grid      <= seed;
        gen_count <= '0;
        divider   <= '0;
        stable    <= 1'b0;
        extinct   <= (seed == 64'd0);
        state     <= IDLE;
        running   <= 1'b0;
      end else if (do_commit) begin
        grid      <= grid_next;
        gen_count <= gen_count_inc;
        gen_tick  <= 1'b1;
        stable    <= nxt_stable;
        extinct   <= nxt_extinct;
        divider   <= '0;
        if (halt_hit) begin
          state   <= HALT;
          running <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= RUN;
              running <= 1'b1;
              divider <= '0;
            end
          end
          RUN: begin
            if (stop) begin
              state   <= IDLE;
              running <= 1'b0;
              divider <= '0;
            end else begin
              divider <= divider + DIV_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
